// File: rtl/shift_add_mult_4bits.sv
// 4x4 unsigned sequential multiplier: one conditional add plus right shift per
// clock, with every partial-product add done by a 4-bit carry-lookahead slice.

module carry_look_ahead_4bits (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [3:0] g_s;
    logic [3:0] p_s;
    logic [4:0] c_s;

    assign g_s = a & b;
    assign p_s = a ^ b;

    // Flattened lookahead carries; no ripple between bit positions.
    assign c_s[0] = cin;
    assign c_s[1] = g_s[0] | (p_s[0] & cin);
    assign c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & cin);
    assign c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
                  | (p_s[2] & p_s[1] & p_s[0] & cin);
    assign c_s[4] = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
                  | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
                  | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & cin);

    assign sum  = p_s ^ c_s[3:0];
    assign cout = c_s[4];
endmodule

module shift_add_mult_4bits (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] product,
    output logic       busy,
    output logic       done
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] m_q, m_d;
    logic [3:0] q_q, q_d;
    logic [3:0] acc_q, acc_d;
    logic       c_q, c_d;
    logic [1:0] count_q, count_d;
    logic [7:0] product_q, product_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic [3:0] sum_s;
    logic       cout_s;
    logic       c_add_s;
    logic [3:0] acc_add_s;

    carry_look_ahead_4bits u_cla (
        .a    (acc_q),
        .b    (m_q),
        .cin  (1'b0),
        .sum  (sum_s),
        .cout (cout_s)
    );

    // Post-add {C',A'}: the carry-out is kept as a ninth bit so 15*15 stays exact.
    always_comb begin
        c_add_s   = 1'b0;
        acc_add_s = acc_q;
        if (q_q[0]) begin
            c_add_s   = cout_s;
            acc_add_s = sum_s;
        end else begin
            c_add_s   = 1'b0;
            acc_add_s = acc_q;
        end
    end

    // Next-state and datapath update for the IDLE/CALC/DONE sequencer.
    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        q_d       = q_q;
        acc_d     = acc_q;
        c_d       = c_q;
        count_d   = count_q;
        product_d = product_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    m_d     = a;
                    q_d     = b;
                    acc_d   = 4'd0;
                    c_d     = 1'b0;
                    count_d = 2'd0;
                    state_d = CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                c_d     = 1'b0;
                acc_d   = {c_add_s, acc_add_s[3:1]};
                q_d     = {acc_add_s[0], q_q[3:1]};
                count_d = count_q + 2'd1;
                if (count_q == 2'd3) begin
                    product_d = {c_add_s, acc_add_s, q_q[3:1]};
                    state_d   = DONE;
                end else begin
                    state_d = CALC;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Status flags are registered from the next state so they line up with it.
    always_comb begin
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State and datapath registers; reset clears everything without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            m_q       <= 4'd0;
            q_q       <= 4'd0;
            acc_q     <= 4'd0;
            c_q       <= 1'b0;
            count_q   <= 2'd0;
            product_q <= 8'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            q_q       <= q_d;
            acc_q     <= acc_d;
            c_q       <= c_d;
            count_q   <= count_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign product = product_q;
    assign busy    = busy_q;
    assign done    = done_q;
endmodule

// File: tb/tb_shift_add_mult_4bits.sv
// Self-checking bench for shift_add_mult_4bits; expected products come from a*b.

module tb_shift_add_mult_4bits;
    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] product;
    logic       busy;
    logic       done;

    int n_cmp;
    int n_fail;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] exp;
    } vec_t;

    shift_add_mult_4bits dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .product (product),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Samples on falling edges: index 0 is the falling edge right after acceptance.
    task automatic watch(input int n, output int dcnt, output int bcnt,
                         output int didx, output logic [7:0] pd);
        dcnt = 0; bcnt = 0; didx = -1; pd = 8'd0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            if (busy) bcnt++;
            if (done) begin
                dcnt++;
                if (didx < 0) begin
                    didx = i;
                    pd   = product;
                end
            end
        end
    endtask

    task automatic run_op(input logic [3:0] ai, input logic [3:0] bi,
                          input string name, input bit full);
        int dcnt, bcnt, didx;
        logic [7:0] pd;
        int exp;
        exp = int'(ai) * int'(bi);
        a = ai; b = bi; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a = 4'($urandom); b = 4'($urandom);
        watch(7, dcnt, bcnt, didx, pd);
        check({name, "_product"}, int'(pd), exp);
        if (full) begin
            check({name, "_done_cnt"}, dcnt, 1);
            check({name, "_done_at"}, didx, 4);
            check({name, "_busy_cycles"}, bcnt, 5);
            check({name, "_hold"}, int'(product), exp);
        end
    endtask

    initial begin
        vec_t vecs[6];
        int dcnt, bcnt, didx, last_done, gap_bad, low_seen, prod_bad;
        logic [7:0] pd;

        n_cmp = 0; n_fail = 0;
        vecs[0] = '{4'd15, 4'd15, 8'hE1};
        vecs[1] = '{4'd9,  4'd6,  8'h36};
        vecs[2] = '{4'd0,  4'd13, 8'h00};
        vecs[3] = '{4'd1,  4'd15, 8'h0F};
        vecs[4] = '{4'd15, 4'd0,  8'h00};
        vecs[5] = '{4'd12, 4'd11, 8'h84};

        rst_n = 1'b0; start = 1'b0; a = 4'd0; b = 4'd0;
        repeat (3) @(negedge clk);
        check("reset_product", int'(product), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].a, vecs[i].b, $sformatf("vec%0d", i), 1'b1);
            check($sformatf("vec%0d_table", i), int'(product), int'(vecs[i].exp));
        end

        // start held high: operations repeat, each done isolated, idle gap between.
        a = 4'd3; b = 4'd5; start = 1'b1;
        @(posedge clk);
        dcnt = 0; last_done = -10; gap_bad = 0; low_seen = 0; prod_bad = 0;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            if (!busy) low_seen++;
            if (done) begin
                dcnt++;
                if (product != 8'h0F) prod_bad++;
                if (i - last_done < 5) gap_bad++;
                last_done = i;
            end
        end
        start = 1'b0;
        check("cont_done_cnt", dcnt, 3);
        check("cont_product_bad", prod_bad, 0);
        check("cont_gap_bad", gap_bad, 0);
        check("cont_idle_cycles", (low_seen >= 2) ? 1 : 0, 1);
        repeat (7) @(negedge clk);

        // Operands and start changed during CALC must not disturb the result.
        a = 4'd7; b = 4'd7; start = 1'b1;
        @(posedge clk);
        dcnt = 0; pd = 8'd0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) begin dcnt++; pd = product; end
            a = 4'd1; b = 4'd1;
            start = (i < 4) ? 1'b1 : 1'b0;
        end
        check("midchg_product", int'(pd), 8'h31);
        check("midchg_done_cnt", dcnt, 1);

        // Async reset during the second CALC cycle aborts the operation.
        a = 4'd5; b = 4'd5; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_product", int'(product), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        watch(7, dcnt, bcnt, didx, pd);
        check("abort_no_done", dcnt, 0);
        check("abort_no_busy", bcnt, 0);
        run_op(4'd2, 4'd8, "after_reset", 1'b1);

        for (int i = 0; i < 30; i++)
            run_op(4'($urandom), 4'($urandom), $sformatf("rand%0d", i), 1'b1);

        for (int i = 0; i < 256; i++)
            run_op(4'(i >> 4), 4'(i & 15), $sformatf("exh_%0d_%0d", i >> 4, i & 15), 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
